// File: rtl/sevseg_scan_driver.sv
// ---------------------------------------------------------------------------
// sevseg_scan_driver
//
// Time-multiplexed seven-segment driver for NUM_DIGITS hex digits sharing one
// set of segment lines. Each digit is driven for REFRESH_DIV cycles, separated
// by GAP_CYCLES cycles with every digit deselected so the previous digit's
// pattern cannot ghost onto the next one. New display data is staged in a
// shadow register and only copied into the display register at the start of
// a frame (the transition into digit 0), so a frame never mixes old and new
// digits.
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   value        in   packed hex nibbles, nibble k = value[4k+3:4k], digit 0 = LSB
//   dp_in        in   decimal point per digit, 1 = lit
//   lz_en        in   1 = suppress leading zeros
//   load         in   1-cycle strobe capturing value/dp_in/lz_en into the shadow
//   pending      out  shadow holds data not yet shown
//   seg          out  segments, bit0 = a .. bit6 = g, polarity per SEG_ACTIVE_LOW
//   dp           out  decimal point, same polarity as seg
//   dig_en       out  one-hot digit select, polarity per DIG_ACTIVE_LOW
//   frame_tick   out  1-cycle pulse in the first cycle digit 0 is driven
//   scan_active  out  debug view of the scan FSM: 1 = SCAN, 0 = GAP
//
// Load handshake: load has no ready; it is accepted in every cycle it is high.
// A load while pending=1 replaces the staged data (latest wins). pending rises
// the cycle after a load and falls the cycle after the shadow is transferred,
// unless a load coincides with that transfer, in which case the transfer
// takes the older shadow and the new data stays pending.
//
// All pin outputs are registered: they reflect the FSM state and digit index
// of the previous cycle.
// ---------------------------------------------------------------------------
module sevseg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int GAP_CYCLES     = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_en,
    input  logic                    load,
    output logic                    pending,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_tick,
    output logic                    scan_active
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    // "Off" levels for each pin group; XOR-ing an active-high pattern with
    // these yields the pin level for the configured polarity.
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [6:0]            SEG_OFF = {7{DP_OFF}};
    localparam logic                  DIG_OFF_BIT = (DIG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_OFF_BIT}};

    typedef enum logic {
        ST_GAP  = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t           state;
    logic [GAP_W-1:0] gap_cnt;
    logic [REF_W-1:0] ref_cnt;
    logic [IDX_W-1:0] idx;

    logic [4*NUM_DIGITS-1:0] shadow_value;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic                    shadow_lz;
    logic [4*NUM_DIGITS-1:0] disp_value;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic                    disp_lz;

    logic                  start_frame;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  blank;
    logic [NUM_DIGITS-1:0] sel;
    logic [6:0]            glyph_on;

    assign scan_active = (state == ST_SCAN);

    // The index has already advanced to 0 during the gap before digit 0, so
    // the last gap cycle with idx==0 is the frame boundary.
    assign start_frame = (state == ST_GAP) && (gap_cnt == GAP_LAST) && (idx == '0);

    // -----------------------------------------------------------------------
    // Scan FSM: counters clear on every state entry.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_GAP;
            gap_cnt <= '0;
            ref_cnt <= '0;
            idx     <= '0;
        end else begin
            case (state)
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state   <= ST_SCAN;
                        gap_cnt <= '0;
                        ref_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (ref_cnt == REF_LAST) begin
                        state   <= ST_GAP;
                        gap_cnt <= '0;
                        ref_cnt <= '0;
                        idx     <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                    end else begin
                        ref_cnt <= ref_cnt + 1'b1;
                    end
                end
                default: state <= ST_GAP;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Shadow / display registers. The shadow always holds the newest data, so
    // copying it unconditionally at a frame start is harmless when nothing is
    // pending (shadow and display are then already equal).
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_value <= '0;
            shadow_dp    <= '0;
            shadow_lz    <= 1'b0;
            disp_value   <= '0;
            disp_dp      <= '0;
            disp_lz      <= 1'b0;
            pending      <= 1'b0;
        end else begin
            if (start_frame) begin
                disp_value <= shadow_value;
                disp_dp    <= shadow_dp;
                disp_lz    <= shadow_lz;
            end
            if (load) begin
                shadow_value <= value;
                shadow_dp    <= dp_in;
                shadow_lz    <= lz_en;
                pending      <= 1'b1;
            end else if (start_frame) begin
                pending <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Current digit selection and leading-zero blanking. A digit is blank when
    // it and every more significant nibble are zero; digit 0 is never blank.
    // -----------------------------------------------------------------------
    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        sel     = '0;
        blank   = disp_lz && (idx != '0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib = disp_value[4*k +: 4];
                cur_dp  = disp_dp[k];
                sel[k]  = 1'b1;
            end
            if ((k >= int'(idx)) && (disp_value[4*k +: 4] != 4'h0)) begin
                blank = 1'b0;
            end
        end
    end

    // Active-high glyph table, bit0 = a .. bit6 = g.
    always_comb begin
        case (cur_nib)
            4'h0: glyph_on = 7'h3F;
            4'h1: glyph_on = 7'h06;
            4'h2: glyph_on = 7'h5B;
            4'h3: glyph_on = 7'h4F;
            4'h4: glyph_on = 7'h66;
            4'h5: glyph_on = 7'h6D;
            4'h6: glyph_on = 7'h7D;
            4'h7: glyph_on = 7'h07;
            4'h8: glyph_on = 7'h7F;
            4'h9: glyph_on = 7'h6F;
            4'hA: glyph_on = 7'h77;
            4'hB: glyph_on = 7'h7C;
            4'hC: glyph_on = 7'h39;
            4'hD: glyph_on = 7'h5E;
            4'hE: glyph_on = 7'h79;
            default: glyph_on = 7'h71;
        endcase
    end

    // -----------------------------------------------------------------------
    // Registered pin outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            dig_en     <= DIG_OFF;
            frame_tick <= 1'b0;
        end else if (state == ST_SCAN) begin
            seg        <= (blank ? 7'h00 : glyph_on) ^ SEG_OFF;
            dp         <= cur_dp ^ DP_OFF;
            dig_en     <= sel ^ DIG_OFF;
            frame_tick <= (idx == '0) && (ref_cnt == '0);
        end else begin
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            dig_en     <= DIG_OFF;
            frame_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_sevseg_scan_driver
//
// Bench for sevseg_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4, GAP_CYCLES=1,
// both polarities active-low. The driver loads directed vectors and pushes the
// hand-computed pin patterns of each future frame into exp_q; the monitor pops
// one entry at the first cycle of every digit slot and also checks gap
// darkness, one-hot select, pattern stability, frame_tick placement and period.
// ---------------------------------------------------------------------------
module tb_sevseg_scan_driver;

  localparam int ND = 4;

  // clock / reset
  logic clk;
  logic reset_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4*ND-1:0] value;
  logic [ND-1:0]   dp_in;
  logic            lz_en;
  logic            load;
  logic            pending;
  logic [6:0]      seg;
  logic            dp;
  logic [ND-1:0]   dig_en;
  logic            frame_tick;
  logic            scan_active;

  sevseg_scan_driver #(
    .NUM_DIGITS    (ND),
    .REFRESH_DIV   (4),
    .GAP_CYCLES    (1),
    .SEG_ACTIVE_LOW(1),
    .DIG_ACTIVE_LOW(1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .value      (value),
    .dp_in      (dp_in),
    .lz_en      (lz_en),
    .load       (load),
    .pending    (pending),
    .seg        (seg),
    .dp         (dp),
    .dig_en     (dig_en),
    .frame_tick (frame_tick),
    .scan_active(scan_active)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard entry: {dig_en, seg, dp}
  logic [11:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Active-low segment words per digit 0..3 and decimal points lit (1 = lit).
  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] dp_lit);
    logic [6:0] s[4];
    logic [3:0] one;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    one = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({~(one << k), s[k], ~dp_lit[k]});
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic lz);
    value = v;
    dp_in = d;
    lz_en = lz;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    check("pending_after_load", pending, 1);
  endtask

  task automatic wait_tick(input int exp_n);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 100);
    if (!frame_tick) begin
      checks++;
      errors++;
      $display("FAIL frame_tick_timeout: got none after %0d cycles expected one", n);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
    check("tick_latency", n, exp_n);
  endtask

  task automatic check_reset_pins();
    check("rst_dig_en", dig_en, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_pending", pending, 0);
    check("rst_frame_tick", frame_tick, 0);
  endtask

  // monitor
  logic [11:0] cur_exp;
  logic [3:0]  prev_dig;
  int          cyc;
  int          last_tick;

  initial begin
    cur_exp   = '0;
    prev_dig  = 4'hF;
    cyc       = 0;
    last_tick = -1;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_dig  = 4'hF;
        cyc       = 0;
        last_tick = -1;
      end else begin
        cyc++;
        check("dig_onehot_or_off", (dig_en == 4'hF) || $onehot(~dig_en), 1);
        if (dig_en == 4'hF) begin
          check("gap_dark", {seg, dp}, 8'hFF);
        end else if (prev_dig == 4'hF) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL slot_unexpected: got %0h expected no slot", {dig_en, seg, dp});
          end else begin
            cur_exp = exp_q.pop_front();
            check("slot", {dig_en, seg, dp}, cur_exp);
          end
        end else begin
          check("slot_hold", {dig_en, seg, dp}, cur_exp);
        end
        check("frame_tick_place", frame_tick, (dig_en == 4'hE) && (prev_dig == 4'hF));
        if (frame_tick) begin
          if (last_tick >= 0) check("tick_period", cyc - last_tick, 20);
          last_tick = cyc;
        end
        prev_dig = dig_en;
      end
    end
  end

  // stimulus
  initial begin
    reset_n = 1'b0;
    value   = '0;
    dp_in   = '0;
    lz_en   = 1'b0;
    load    = 1'b0;

    // frame 0: reset display value 0 shows "0" on every digit
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);
    idle(2);
    #1;
    check_reset_pins();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_dark", dig_en, 4'hF);
    wait_tick(1);

    // frame 1: 12AF -> F, A, 2, 1
    do_load(16'h12AF, 4'b0000, 1'b0);
    push_frame(7'h0E, 7'h08, 7'h24, 7'h79, 4'b0000);
    wait_tick(19);

    // frame 2: 0030 with suppression -> 0, 3, blank, blank
    do_load(16'h0030, 4'b0000, 1'b1);
    push_frame(7'h40, 7'h30, 7'h7F, 7'h7F, 4'b0000);
    wait_tick(19);

    // frame 3: 0000 with suppression, dp on digit 2 (blank digit keeps dp)
    do_load(16'h0000, 4'b0100, 1'b1);
    push_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0100);
    wait_tick(19);

    // frame 3 continues showing old data; two loads, latest wins in frame 4
    idle(3);
    do_load(16'h1111, 4'b0000, 1'b0);
    idle(3);
    do_load(16'h2222, 4'b0000, 1'b0);
    push_frame(7'h24, 7'h24, 7'h24, 7'h24, 4'b0000);
    idle(10);
    check("pending_before_frame", pending, 1);
    wait_tick(2);
    check("pending_at_tick", pending, 0);

    // frame 5: 89CD, dp digit 2
    do_load(16'h89CD, 4'b0100, 1'b0);
    push_frame(7'h21, 7'h46, 7'h10, 7'h00, 4'b0100);
    wait_tick(19);

    // frame 6 gets 4567; BEEF loaded in the transfer cycle waits for frame 7
    idle(3);
    do_load(16'h4567, 4'b1001, 1'b0);
    push_frame(7'h78, 7'h02, 7'h12, 7'h19, 4'b1001);
    idle(14);
    do_load(16'hBEEF, 4'b0000, 1'b0);
    push_frame(7'h0E, 7'h06, 7'h06, 7'h03, 4'b0000);
    wait_tick(1);
    check("pending_held_over", pending, 1);
    wait_tick(20);
    check("pending_cleared", pending, 0);

    // frame 7: stage data, then reset while digit 2 is driven
    do_load(16'h0000, 4'b1111, 1'b0);
    idle(10);
    check("digit2_driven", dig_en, 4'hB);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_pins();
    exp_q.delete();
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("restart_dark", dig_en, 4'hF);
    wait_tick(1);
    idle(19);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
